// File: rtl/demux_1to2_buf_if.sv
// demux_1to2_buf_if: input stream plus two output streams of the 1-to-2 buffered demux
interface demux_1to2_buf_if #(parameter int size = 32);
   logic [size-1:0] data_i;
   logic            select_i;
   logic            valid_i;
   logic            ready_o;
   logic [size-1:0] data0_o;
   logic            valid0_o;
   logic            ready0_i;
   logic [size-1:0] data1_o;
   logic            valid1_o;
   logic            ready1_i;
   modport master (
      output data_i, select_i, valid_i, ready0_i, ready1_i,
      input  ready_o, data0_o, valid0_o, data1_o, valid1_o
   );
   modport slave (
      input  data_i, select_i, valid_i, ready0_i, ready1_i,
      output ready_o, data0_o, valid0_o, data1_o, valid1_o
   );
endinterface

// File: rtl/demux_1to2_buf.sv
// demux_1to2_buf: steers each input beat into one of two 2-entry FIFOs; DEMUX_BEAT_CNT_EN adds delivered-beat counters
module demux_1to2_buf #(
   parameter int size = 32
) (
   input logic clk_i,
   input logic rst_i,
   demux_1to2_buf_if.slave bus
`ifdef DEMUX_BEAT_CNT_EN
   ,
   output logic [15:0] cnt0_o,
   output logic [15:0] cnt1_o
`endif
);
   logic [size-1:0] mem [2][2];
   logic [1:0] wr_ptr;
   logic [1:0] rd_ptr;
   logic [1:0] cnt [2];
   logic [1:0] valid;
   logic [1:0] push;
   logic [1:0] pop;
   // Acceptance looks only at registered counts, so a full FIFO refuses even while it pops.
   assign bus.ready_o = (bus.select_i ? cnt[1] : cnt[0]) < 2'd2;
   assign push = (bus.valid_i && bus.ready_o) ? (bus.select_i ? 2'b10 : 2'b01) : 2'b00;
   assign valid = {cnt[1] != 2'd0, cnt[0] != 2'd0};
   assign pop = valid & {bus.ready1_i, bus.ready0_i};
   assign bus.valid0_o = valid[0];
   assign bus.valid1_o = valid[1];
   assign bus.data0_o = valid[0] ? mem[0][rd_ptr[0]] : '0;
   assign bus.data1_o = valid[1] ? mem[1][rd_ptr[1]] : '0;
   // Per-port FIFO state: write on push, advance head on pop, count tracks the difference.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int k = 0; k < 2; k++) begin
            mem[k][0] <= '0;
            mem[k][1] <= '0;
            cnt[k] <= 2'd0;
         end
         wr_ptr <= 2'b00;
         rd_ptr <= 2'b00;
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (push[k]) begin
               mem[k][wr_ptr[k]] <= bus.data_i;
               wr_ptr[k] <= ~wr_ptr[k];
            end
            if (pop[k]) rd_ptr[k] <= ~rd_ptr[k];
            cnt[k] <= cnt[k] + {1'b0, push[k]} - {1'b0, pop[k]};
         end
      end
   end
`ifdef DEMUX_BEAT_CNT_EN
   // Delivered-beat counters, free-running and wrapping at 16 bits.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt0_o <= 16'd0;
         cnt1_o <= 16'd0;
      end else begin
         if (pop[0]) cnt0_o <= cnt0_o + 16'd1;
         if (pop[1]) cnt1_o <= cnt1_o + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_demux_1to2_buf.sv
// tb_demux_1to2_buf: table-driven vectors plus queue scoreboard for demux_1to2_buf (DEMUX_BEAT_CNT_EN optional)
module tb_demux_1to2_buf;
   logic clk_i = 1'b0;
   logic rst_i = 1'b0;
   int checks = 0;
   int errors = 0;
   logic [31:0] q0 [$];
   logic [31:0] q1 [$];
   logic exp_ready;
   logic [15:0] exp_cnt0 = 16'd0;
   logic [15:0] exp_cnt1 = 16'd0;
   demux_1to2_buf_if #(.size(32)) bus ();
`ifdef DEMUX_BEAT_CNT_EN
   logic [15:0] cnt0_o, cnt1_o;
   demux_1to2_buf #(.size(32)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus.slave), .cnt0_o(cnt0_o), .cnt1_o(cnt1_o));
`else
   demux_1to2_buf #(.size(32)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus.slave));
`endif
   always #5 clk_i = ~clk_i;
   typedef struct {
      logic valid;
      logic sel;
      logic [31:0] data;
      logic r0;
      logic r1;
      logic exp_ready;
   } vec_t;
   vec_t vt [14];
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask
   // Scoreboard: compare outputs with the queue model before each edge, then apply that edge's pops and push.
   always @(negedge clk_i) begin
      if (!rst_i) begin
         q0.delete();
         q1.delete();
         exp_cnt0 = 16'd0;
         exp_cnt1 = 16'd0;
         chk("rst_valid0", {31'd0, bus.valid0_o}, 32'd0);
         chk("rst_valid1", {31'd0, bus.valid1_o}, 32'd0);
         chk("rst_data0", bus.data0_o, 32'd0);
         chk("rst_data1", bus.data1_o, 32'd0);
         chk("rst_ready", {31'd0, bus.ready_o}, 32'd1);
`ifdef DEMUX_BEAT_CNT_EN
         chk("rst_cnt0", {16'd0, cnt0_o}, 32'd0);
         chk("rst_cnt1", {16'd0, cnt1_o}, 32'd0);
`endif
      end else begin
         exp_ready = (bus.select_i ? q1.size() : q0.size()) < 2;
         chk("sb_ready", {31'd0, bus.ready_o}, {31'd0, exp_ready});
         chk("sb_valid0", {31'd0, bus.valid0_o}, {31'd0, q0.size() != 0});
         chk("sb_valid1", {31'd0, bus.valid1_o}, {31'd0, q1.size() != 0});
         chk("sb_data0", bus.data0_o, q0.size() != 0 ? q0[0] : 32'd0);
         chk("sb_data1", bus.data1_o, q1.size() != 0 ? q1[0] : 32'd0);
`ifdef DEMUX_BEAT_CNT_EN
         chk("sb_cnt0", {16'd0, cnt0_o}, {16'd0, exp_cnt0});
         chk("sb_cnt1", {16'd0, cnt1_o}, {16'd0, exp_cnt1});
`endif
         if (q0.size() != 0 && bus.ready0_i) begin
            void'(q0.pop_front());
            exp_cnt0 = exp_cnt0 + 16'd1;
         end
         if (q1.size() != 0 && bus.ready1_i) begin
            void'(q1.pop_front());
            exp_cnt1 = exp_cnt1 + 16'd1;
         end
         if (bus.valid_i && exp_ready) begin
            if (bus.select_i) q1.push_back(bus.data_i);
            else q0.push_back(bus.data_i);
         end
      end
   end
   initial begin
      vt[0]  = '{1'b1, 1'b0, 32'hA5A5A5A5, 1'b1, 1'b1, 1'b1};
      vt[1]  = '{1'b1, 1'b1, 32'h12345678, 1'b1, 1'b1, 1'b1};
      vt[2]  = '{1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
      vt[3]  = '{1'b1, 1'b0, 32'h00000001, 1'b0, 1'b1, 1'b1};
      vt[4]  = '{1'b1, 1'b0, 32'h00000002, 1'b0, 1'b1, 1'b1};
      vt[5]  = '{1'b1, 1'b0, 32'h00000003, 1'b0, 1'b1, 1'b0};
      vt[6]  = '{1'b1, 1'b0, 32'h00000003, 1'b0, 1'b1, 1'b0};
      vt[7]  = '{1'b1, 1'b1, 32'h0000BEEF, 1'b0, 1'b1, 1'b1};
      vt[8]  = '{1'b1, 1'b0, 32'h00000003, 1'b1, 1'b1, 1'b0};
      vt[9]  = '{1'b1, 1'b0, 32'h00000003, 1'b1, 1'b1, 1'b1};
      vt[10] = '{1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
      vt[11] = '{1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
      vt[12] = '{1'b1, 1'b1, 32'h00000055, 1'b1, 1'b0, 1'b1};
      vt[13] = '{1'b1, 1'b1, 32'h00000066, 1'b1, 1'b0, 1'b1};
      bus.valid_i = 1'b0;
      bus.select_i = 1'b0;
      bus.data_i = 32'd0;
      bus.ready0_i = 1'b1;
      bus.ready1_i = 1'b1;
      #1;
      chk("init_ready", {31'd0, bus.ready_o}, 32'd1);
      chk("init_valid0", {31'd0, bus.valid0_o}, 32'd0);
      chk("init_data1", bus.data1_o, 32'd0);
      repeat (2) @(posedge clk_i);
      #3 rst_i = 1'b1;
      repeat (2) @(posedge clk_i);
      for (int i = 0; i < 14; i++) begin
         @(posedge clk_i);
         #1;
         bus.valid_i = vt[i].valid;
         bus.select_i = vt[i].sel;
         bus.data_i = vt[i].data;
         bus.ready0_i = vt[i].r0;
         bus.ready1_i = vt[i].r1;
         #3 chk($sformatf("vec%0d_ready", i), {31'd0, bus.ready_o}, {31'd0, vt[i].exp_ready});
      end
      @(posedge clk_i);
      #1;
      bus.valid_i = 1'b0;
      bus.select_i = 1'b1;
      bus.ready1_i = 1'b0;
      #2 chk("full1_ready", {31'd0, bus.ready_o}, 32'd0);
      chk("pre_rst_valid1", {31'd0, bus.valid1_o}, 32'd1);
      rst_i = 1'b0;
      #1 chk("async_valid1", {31'd0, bus.valid1_o}, 32'd0);
      chk("async_data1", bus.data1_o, 32'd0);
      chk("async_ready", {31'd0, bus.ready_o}, 32'd1);
      repeat (2) @(posedge clk_i);
      #3 rst_i = 1'b1;
      bus.ready0_i = 1'b1;
      bus.ready1_i = 1'b1;
      repeat (4) @(posedge clk_i);
      #2 chk("post_rst_valid1", {31'd0, bus.valid1_o}, 32'd0);
      chk("post_rst_valid0", {31'd0, bus.valid0_o}, 32'd0);
`ifdef DEMUX_BEAT_CNT_EN
      for (int i = 0; i < 65536; i++) begin
         @(posedge clk_i);
         #1;
         bus.valid_i = 1'b1;
         bus.select_i = 1'b0;
         bus.data_i = i;
      end
      @(posedge clk_i);
      #1 bus.valid_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #2 chk("cnt0_wrap", {16'd0, cnt0_o}, 32'd0);
      chk("cnt1_hold", {16'd0, cnt1_o}, 32'd0);
`endif
      @(posedge clk_i);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
